// File: rtl/mips_fetch_queue.sv
// Instruction prefetch queue: issues sequential word fetches with at most one request
// outstanding, buffers returned words with their PCs in a FIFO, and squashes on redirect.
module mips_fetch_queue #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic                       imem_req,
  output logic [ADDR_W-1:0]          imem_addr,
  input  logic                       imem_rvalid,
  input  logic [31:0]                imem_rdata,
  input  logic                       redirect_valid,
  input  logic [ADDR_W-1:0]          redirect_pc,
  output logic                       ir_valid,
  input  logic                       ir_ready,
  output logic [31:0]                ir_data,
  output logic [ADDR_W-1:0]          ir_pc,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [CntW:0] DepthLvl = (CntW + 1)'(DEPTH);

  typedef enum logic [1:0] {StIdle, StBusy, StFlush} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q;
  logic [ADDR_W-1:0] addr_q;      // address of the most recent (possibly outstanding) request
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   count_q, count_d;
  logic [31:0]       data_q [DEPTH];
  logic [ADDR_W-1:0] pc_q   [DEPTH];

  logic              push, pop, issue;
  logic [CntW:0]     level;
  logic              unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  always_comb begin
    push    = (state_q == StBusy) && imem_rvalid && !redirect_valid;
    pop     = (count_q != '0) && ir_ready && !redirect_valid;
    level   = {1'b0, count_q} + {{CntW{1'b0}}, push} - {{CntW{1'b0}}, pop};
    // Gated by reset so no request is visible while the block is held in reset.
    issue   = reset && !redirect_valid && (level < DepthLvl) &&
              ((state_q == StIdle) || ((state_q == StBusy) && imem_rvalid));
    count_d = count_q + CntW'(push) - CntW'(pop);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (issue) state_d = StBusy;
      end
      StBusy: begin
        if (redirect_valid) begin
          state_d = imem_rvalid ? StIdle : StFlush;
        end else if (imem_rvalid) begin
          state_d = issue ? StBusy : StIdle;
        end
      end
      StFlush: begin
        if (imem_rvalid) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign imem_req  = issue;
  assign imem_addr = issue ? fetch_pc_q : addr_q;
  assign ir_valid  = (count_q != '0);
  assign ir_data   = data_q[rd_ptr_q];
  assign ir_pc     = pc_q[rd_ptr_q];
  assign count     = count_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      data_q     <= '{default: '0};
      pc_q       <= '{default: '0};
    end else begin
      state_q <= state_d;
      if (redirect_valid) begin
        fetch_pc_q <= {redirect_pc[ADDR_W-1:2], 2'b00};
        wr_ptr_q   <= '0;
        rd_ptr_q   <= '0;
        count_q    <= '0;
      end else begin
        if (issue) begin
          fetch_pc_q <= fetch_pc_q + ADDR_W'(4);
          addr_q     <= fetch_pc_q;
        end
        if (push) begin
          data_q[wr_ptr_q] <= imem_rdata;
          pc_q[wr_ptr_q]   <= addr_q;
          wr_ptr_q         <= wr_ptr_q + PtrW'(1);
        end
        if (pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
        count_q <= count_d;
      end
    end
  end

endmodule

// File: tb/tb_mips_fetch_queue.sv
// Bench for mips_fetch_queue: directed scenarios plus randomized traffic checked every cycle
// against a transaction-level model (queue of {data, pc}, one outstanding-request flag).
module tb_mips_fetch_queue;
  localparam int          DEPTH   = 4;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFC;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req, imem_rvalid, redirect_valid, ir_valid, ir_ready;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, ir_data, ir_pc;
  logic [2:0]  count;

  logic        imem_req2, imem_rvalid2, ir_valid2;
  logic [31:0] imem_addr2, imem_rdata2, ir_data2, ir_pc2;
  logic [2:0]  count2;

  always #5 clk = ~clk;

  mips_fetch_queue #(.ADDR_W(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .ir_valid(ir_valid), .ir_ready(ir_ready), .ir_data(ir_data),
    .ir_pc(ir_pc), .count(count)
  );

  mips_fetch_queue #(.ADDR_W(32), .DEPTH(DEPTH), .RESET_PC(WRAP_PC)) dut_wrap (
    .clk(clk), .reset(reset), .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_rvalid(imem_rvalid2), .imem_rdata(imem_rdata2), .redirect_valid(1'b0),
    .redirect_pc(32'h0), .ir_valid(ir_valid2), .ir_ready(1'b1), .ir_data(ir_data2),
    .ir_pc(ir_pc2), .count(count2)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model
  logic [31:0] q_data[$];
  logic [31:0] q_pc[$];
  logic [31:0] m_fetch, m_addr;
  bit          m_outst, m_discard;
  bit          c_issue, c_push, c_pop, c_req, c_req2;
  logic [31:0] c_addr;

  // Memory and stimulus configuration
  bit          mem_pend;
  int          mem_cnt;
  logic [31:0] mem_a;
  int          lat_min, lat_max, ready_pct, redir_pct;
  bit          redir_once;
  logic [31:0] redir_once_pc;

  // Event logs for directed checks
  logic [31:0] cyc;
  logic [31:0] req_log[$], req_cyc[$], pop_log[$], pop_cyc[$];
  logic [31:0] cnt_log[$], val_log[$], rv_log[$], w_log[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] at(input logic [31:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hDEAD_BEEF;
  endfunction

  always @(negedge clk) begin
    int          lvl;
    logic [31:0] e_addr;
    cyc    = cyc + 1;
    c_req  = imem_req;
    c_addr = imem_addr;
    c_req2 = imem_req2;
    if (imem_req) begin
      req_log.push_back(imem_addr);
      req_cyc.push_back(cyc);
    end
    if (ir_valid && ir_ready && !redirect_valid) begin
      pop_log.push_back(ir_pc);
      pop_cyc.push_back(cyc);
    end
    cnt_log.push_back(32'(count));
    val_log.push_back(32'(ir_valid));
    rv_log.push_back(32'(imem_rvalid));
    if (reset && ir_valid2 && w_log.size() < 2) w_log.push_back(ir_pc2);
    if (!reset) begin
      c_issue = 0;
      c_push  = 0;
      c_pop   = 0;
      chk("reset_imem_req", 64'(imem_req), 64'(0));
      chk("reset_imem_addr", 64'(imem_addr), 64'(0));
      chk("reset_ir_valid", 64'(ir_valid), 64'(0));
      chk("reset_count", 64'(count), 64'(0));
      chk("reset_ir_pc", 64'(ir_pc), 64'(0));
      chk("reset_ir_data", 64'(ir_data), 64'(0));
    end else begin
      c_push  = m_outst && !m_discard && imem_rvalid && !redirect_valid;
      c_pop   = (q_pc.size() != 0) && ir_ready && !redirect_valid;
      lvl     = q_pc.size() + (c_push ? 1 : 0) - (c_pop ? 1 : 0);
      c_issue = !redirect_valid && (lvl < DEPTH) && (!m_outst || (!m_discard && imem_rvalid));
      e_addr  = c_issue ? m_fetch : m_addr;
      chk("imem_req", 64'(imem_req), 64'(c_issue));
      chk("imem_addr", 64'(imem_addr), 64'(e_addr));
      chk("ir_valid", 64'(ir_valid), 64'(q_pc.size() != 0));
      chk("count", 64'(count), 64'(q_pc.size()));
      if (q_pc.size() != 0) begin
        chk("ir_pc", 64'(ir_pc), 64'(q_pc[0]));
        chk("ir_data", 64'(ir_data), 64'(q_data[0]));
      end
    end
  end

  task automatic model_reset();
    q_pc.delete();
    q_data.delete();
    m_fetch   = 32'h0;
    m_addr    = 32'h0;
    m_outst   = 0;
    m_discard = 0;
  endtask

  task automatic clear_logs();
    req_log.delete(); req_cyc.delete(); pop_log.delete(); pop_cyc.delete();
    cnt_log.delete(); val_log.delete(); rv_log.delete();
  endtask

  task automatic step();
    @(posedge clk);
    if (reset) begin
      if (redirect_valid) begin
        q_pc.delete();
        q_data.delete();
        m_fetch = {redirect_pc[31:2], 2'b00};
        if (m_outst && !imem_rvalid) begin
          m_discard = 1;
        end else begin
          m_outst   = 0;
          m_discard = 0;
        end
      end else begin
        if (c_push) begin
          q_data.push_back(imem_rdata);
          q_pc.push_back(m_addr);
        end
        if (c_pop) begin
          q_pc.delete(0);
          q_data.delete(0);
        end
        if (m_outst && imem_rvalid) begin
          m_outst   = 0;
          m_discard = 0;
        end
        if (c_issue) begin
          m_outst = 1;
          m_addr  = m_fetch;
          m_fetch = m_fetch + 32'd4;
        end
      end
    end
    if (imem_rvalid) mem_pend = 0;
    if (c_req) begin
      mem_pend = 1;
      mem_a    = c_addr;
      mem_cnt  = int'($urandom_range(lat_max, lat_min)) - 1;
    end else if (mem_pend) begin
      mem_cnt--;
    end
    #1;
    imem_rvalid  = mem_pend && (mem_cnt == 0);
    imem_rdata   = imem_rvalid ? (mem_a ^ 32'h5A5A_1234) : $urandom();
    imem_rvalid2 = c_req2;
    ir_ready     = int'($urandom_range(99, 0)) < ready_pct;
    if (redir_once) begin
      redirect_valid = 1'b1;
      redirect_pc    = redir_once_pc;
      redir_once     = 0;
    end else begin
      redirect_valid = int'($urandom_range(99, 0)) < redir_pct;
      redirect_pc    = $urandom();
    end
  endtask

  // Hold reset for a few cycles, then release mid-cycle so cycle 0 is the first live cycle.
  task automatic start(input int rp, input int lmin, input int lmax);
    ready_pct = rp;
    lat_min   = lmin;
    lat_max   = lmax;
    redir_pct = 0;
    reset     = 1'b0;
    model_reset();
    repeat (3) step();
    #2 reset = 1'b1;
  endtask

  initial begin
    int max_cnt;
    reset = 1'b0; ir_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    imem_rvalid = 1'b0; imem_rdata = 32'h0; imem_rvalid2 = 1'b0; imem_rdata2 = 32'h1234_5678;
    c_req = 0; c_req2 = 0; c_addr = 32'h0; c_issue = 0; c_push = 0; c_pop = 0;
    mem_pend = 0; mem_cnt = 0; mem_a = 32'h0; cyc = 32'h0; redir_once = 0;
    redir_once_pc = 32'h0;
    model_reset();

    // Streaming, 1-cycle memory, consumer always ready
    start(100, 1, 1);
    clear_logs();
    repeat (8) step();
    chk("stream_pc0", 64'(at(pop_log, 0)), 64'h0);
    chk("stream_pc1", 64'(at(pop_log, 1)), 64'h4);
    chk("stream_pc2", 64'(at(pop_log, 2)), 64'h8);
    chk("stream_pc3", 64'(at(pop_log, 3)), 64'hC);
    chk("stream_consecutive", 64'(at(pop_cyc, 3) - at(pop_cyc, 0)), 64'd3);
    max_cnt = 0;
    foreach (cnt_log[i]) if (int'(cnt_log[i]) > max_cnt) max_cnt = int'(cnt_log[i]);
    chk("stream_max_count", 64'(max_cnt), 64'd1);

    // Back-pressure fills the queue, then the first pop re-opens issue
    start(0, 1, 1);
    clear_logs();
    repeat (8) step();
    chk("bp_req_count", 64'(req_log.size()), 64'd4);
    chk("bp_req0", 64'(at(req_log, 0)), 64'h0);
    chk("bp_req3", 64'(at(req_log, 3)), 64'hC);
    chk("bp_full_count", 64'(at(cnt_log, 7)), 64'd4);
    ready_pct = 100;
    clear_logs();
    repeat (3) step();
    chk("bp_next_req", 64'(at(req_log, 0)), 64'h10);
    chk("bp_req_with_pop", 64'(at(req_cyc, 0)), 64'(at(pop_cyc, 0)));

    // Redirect while a request is outstanding; its data returns two cycles later
    start(100, 3, 3);
    redir_once    = 1;
    redir_once_pc = 32'h103;
    step();
    clear_logs();
    repeat (10) step();
    chk("redir_count_after", 64'(at(cnt_log, 1)), 64'd0);
    chk("redir_next_addr", 64'(at(req_log, 0)), 64'h100);
    chk("redir_first_pc", 64'(at(pop_log, 0)), 64'h100);

    // Redirect, rvalid and pop together with one entry queued
    start(100, 1, 1);
    repeat (3) step();
    redir_once    = 1;
    redir_once_pc = 32'h40;
    step();
    clear_logs();
    repeat (4) step();
    chk("simul_pre_count", 64'(at(cnt_log, 0)), 64'd1);
    chk("simul_pre_rvalid", 64'(at(rv_log, 0)), 64'd1);
    chk("simul_count_t1", 64'(at(cnt_log, 1)), 64'd0);
    chk("simul_valid_t1", 64'(at(val_log, 1)), 64'd0);
    chk("simul_no_push", 64'(at(cnt_log, 2)), 64'd0);
    chk("simul_next_req", 64'(at(req_log, 0)), 64'h40);

    // Asynchronous reset while BUSY with entries queued; stale rvalid lands after release
    start(0, 3, 3);
    repeat (7) step();
    #1;
    chk("rst_pre_count", 64'(count), 64'd2);
    chk("rst_pre_addr", 64'(imem_addr), 64'h8);
    #1 reset = 1'b0;
    #1;
    chk("rst_now_req", 64'(imem_req), 64'd0);
    chk("rst_now_addr", 64'(imem_addr), 64'h0);
    chk("rst_now_valid", 64'(ir_valid), 64'd0);
    chk("rst_now_count", 64'(count), 64'd0);
    chk("rst_now_pc", 64'(ir_pc), 64'h0);
    chk("rst_now_data", 64'(ir_data), 64'h0);
    model_reset();
    repeat (2) step();
    #2 reset = 1'b1;
    clear_logs();
    repeat (5) step();
    chk("rst_stale_rvalid", 64'(at(rv_log, 0)), 64'd1);
    chk("rst_first_req", 64'(at(req_log, 0)), 64'h0);
    chk("rst_no_push", 64'(at(cnt_log, 1)), 64'd0);

    // Randomized traffic
    start(70, 1, 3);
    redir_pct = 6;
    repeat (3000) step();

    chk("wrap_pc0", 64'(at(w_log, 0)), 64'(WRAP_PC));
    chk("wrap_pc1", 64'(at(w_log, 1)), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mips_fetch_queue.md
MIPS_FETCH_QUEUE -- requirements
Module: mips_fetch_queue

Interface
REQ-001 The module SHALL have parameter ADDR_W, default 32, giving the instruction address width.
REQ-002 The module SHALL have parameter DEPTH, default 4, giving prefetch queue entries; it SHALL be a power of two, at least 2.
REQ-003 The module SHALL have parameter RESET_PC, default 0, giving the first fetch address; bits [1:0] SHALL be 0.
REQ-004 The module SHALL have port clk, input, 1 bit: single clock; all state SHALL update on its rising edge.
REQ-005 The module SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 The module SHALL have port imem_req, output, 1 bit: one-cycle fetch request pulse.
REQ-007 The module SHALL have port imem_addr, output, ADDR_W bits: word-aligned fetch address, held until the next request.
REQ-008 The module SHALL have port imem_rvalid, input, 1 bit: read data valid, at least 1 cycle after imem_req.
REQ-009 The module SHALL have port imem_rdata, input, 32 bits: instruction word.
REQ-010 The module SHALL have port redirect_valid, input, 1 bit: taken branch or jump.
REQ-011 The module SHALL have port redirect_pc, input, ADDR_W bits: new fetch target.
REQ-012 The module SHALL have port ir_valid, output, 1 bit: the queue head is valid.
REQ-013 The module SHALL have port ir_ready, input, 1 bit: the consumer accepts the head.
REQ-014 The module SHALL have port ir_data, output, 32 bits: head instruction.
REQ-015 The module SHALL have port ir_pc, output, ADDR_W bits: address of the head instruction.
REQ-016 The module SHALL have port count, output, $clog2(DEPTH+1) bits: queue occupancy.

Function
REQ-017 The module SHALL implement states IDLE (no request outstanding), BUSY (one request outstanding) and FLUSH (the outstanding request is to be discarded), with at most one request outstanding.
REQ-018 fetch_pc SHALL advance by 4 on each issued request, wrapping modulo 2^ADDR_W.
REQ-019 Pop SHALL occur when ir_valid and ir_ready are both 1.
REQ-020 Push SHALL occur when imem_rvalid is 1 in BUSY; the entry SHALL be {imem_rdata, address of the outstanding request}.
REQ-021 The module SHALL issue a request in cycle t only if the state is IDLE, or is BUSY with imem_rvalid=1; redirect_valid=0; and count+push-pop < DEPTH.
REQ-022 A request SHALL pulse imem_req for exactly one cycle and drive imem_addr=fetch_pc in that cycle.
REQ-023 The state SHALL then be BUSY.
REQ-024 In BUSY, imem_rvalid=1 with no reissue SHALL move the state to IDLE; back-to-back issue SHALL sustain one instruction per cycle when rvalid returns after 1 cycle.
REQ-025 Queue entries SHALL be registered: a push at cycle t SHALL be visible on ir_valid, ir_data and ir_pc at cycle t+1.
REQ-026 Queue entries SHALL be popped in FIFO order.
REQ-027 Pointers SHALL wrap modulo DEPTH.
REQ-028 Push and pop in the same cycle SHALL leave count unchanged.
REQ-029 When count=DEPTH there SHALL be no issue; when count=0, ir_valid SHALL be 0 and ir_data, ir_pc are don't-care.
REQ-030 redirect_valid=1 SHALL take priority over push, pop and issue.
REQ-031 On redirect, the queue SHALL be emptied (count=0, ir_valid=0 at t+1).
REQ-032 On redirect, fetch_pc SHALL be set to {redirect_pc[ADDR_W-1:2], 2'b00}.
REQ-033 On redirect, any imem_rvalid in the same cycle SHALL be dropped.
REQ-034 On redirect in BUSY without rvalid, the next state SHALL be FLUSH; otherwise it SHALL be IDLE.
REQ-035 In FLUSH, the returning imem_rvalid SHALL be discarded and the state SHALL go to IDLE.
REQ-036 In FLUSH, a further redirect SHALL update fetch_pc and the state SHALL remain FLUSH.
REQ-037 imem_rvalid in IDLE SHALL be ignored.
REQ-038 Issue after a redirect SHALL occur at the earliest in cycle t+1.

Reset
REQ-039 reset=0 SHALL immediately force state=IDLE, fetch_pc=RESET_PC, queue pointers=0, count=0, imem_req=0, imem_addr=RESET_PC, ir_valid=0, ir_data=0 and ir_pc=0.
REQ-040 The first request SHALL issue in the first clock edge after reset is released.
REQ-041 A stale imem_rvalid arriving after reset SHALL be ignored (the state is IDLE).

Verification
REQ-042 Streaming: DEPTH=4, RESET_PC=0, rvalid 1 cycle after each req, ir_ready=1 -> ir_pc=0x0,0x4,0x8,0xC on consecutive cycles; count never exceeds 1.
REQ-043 Back-pressure: ir_ready=0 -> exactly 4 requests (0x0-0xC), count=4, imem_req stays 0; then ir_ready=1 -> next request 0x10 in the same cycle as the first pop.
REQ-044 Redirect while BUSY: redirect_pc=0x103 with rvalid arriving 2 cycles later -> that data is dropped, count=0, the next imem_addr is 0x100, and the first ir_pc after the redirect is 0x100.
REQ-045 Simultaneous events: redirect, rvalid and pop in one cycle with count=1 -> count=0 at t+1 and no push.
REQ-046 Wrap: RESET_PC=0xFFFFFFFC -> ir_pc=0xFFFFFFFC, then 0x00000000.
REQ-047 Reset mid-BUSY: reset=0 between clock edges -> outputs take their reset values immediately; a later rvalid produces no push; the first request after release is to RESET_PC.
